// File: rtl/pixel_stream_unpacker_if.sv
// Pixel stream unpacker bus bundle.
//   Upstream byte stream : in_data, in_valid, in_sof -> ; <- in_ready
//   Cache write port     : <- wr_en, wr_data, wr_h, wr_v ; wr_ready ->
//   Status / control     : <- frame_done, sync_err ; err_clr ->
// The master modport is the side that feeds bytes and owns the cache (driver);
// the slave modport is the unpacker itself.
interface pixel_stream_unpacker_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic        wr_en;
    logic        wr_ready;
    logic [11:0] wr_data;
    logic [10:0] wr_h;
    logic [10:0] wr_v;
    logic        frame_done;
    logic        sync_err;
    logic        err_clr;

    modport master (
        output in_data, in_valid, in_sof, wr_ready, err_clr,
        input  in_ready, wr_en, wr_data, wr_h, wr_v, frame_done, sync_err
    );

    modport slave (
        input  in_data, in_valid, in_sof, wr_ready, err_clr,
        output in_ready, wr_en, wr_data, wr_h, wr_v, frame_done, sync_err
    );
endinterface

// File: rtl/pixel_stream_unpacker.sv
// Unpacks packed RGB444 bytes (3 bytes -> 2 pixels) into 12-bit pixels and
// hands each one to the frame-cache write port with its column/line address.
// Ports:
//   clk_i  pixel clock
//   rst_i  asynchronous active-high reset
//   bus    slave side of pixel_stream_unpacker_if (byte stream in, cache
//          write port out, frame_done pulse, sticky sync_err with err_clr)
module pixel_stream_unpacker #(
    parameter int H_PIXELS = 800,   // even, <= 2047
    parameter int V_LINES  = 600    // <= 2047
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    pixel_stream_unpacker_if.slave   bus
);
    localparam logic [10:0] H_LAST = 11'(H_PIXELS - 1);
    localparam logic [10:0] V_LAST = 11'(V_LINES - 1);

    typedef enum logic [1:0] {WAIT_SOF, B0, B1, B2} state_t;

    state_t      state_q;
    logic [7:0]  b0_q;
    logic [3:0]  b1_lo_q;
    logic [10:0] h_q, v_q, h_d, v_d;
    logic        wr_en_q, frame_done_q, sync_err_q;
    logic [11:0] wr_data_q;
    logic [10:0] wr_h_q, wr_v_q;

    logic in_ready, accept, wr_done, frame_last, resync, load_last;

    // h_q/v_q count completed writes in the current frame, so they are also
    // the address of the next pixel to retire. A pixel loaded on an edge
    // where the pending one retires takes the post-increment value (h_d/v_d).
    always_comb begin
        in_ready   = !wr_en_q || bus.wr_ready;
        accept     = bus.in_valid && in_ready;
        wr_done    = wr_en_q && bus.wr_ready;
        frame_last = (h_q == H_LAST) && (v_q == V_LAST);
        resync     = accept && bus.in_sof &&
                     ((state_q == B1) || (state_q == B2) ||
                      ((state_q == B0) && ((h_q != '0) || (v_q != '0))));
        h_d = h_q;
        v_d = v_q;
        if (wr_done) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = frame_last ? '0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
        // Resync restarts addressing; the retiring pixel already has its address.
        if (resync) begin
            h_d = '0;
            v_d = '0;
        end
        load_last = (h_d == H_LAST) && (v_d == V_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= WAIT_SOF;
            b0_q         <= '0;
            b1_lo_q      <= '0;
            h_q          <= '0;
            v_q          <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_h_q       <= '0;
            wr_v_q       <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            frame_done_q <= wr_done && frame_last;
            if (resync)           sync_err_q <= 1'b1;
            else if (bus.err_clr) sync_err_q <= 1'b0;
            if (wr_done) wr_en_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    WAIT_SOF: begin
                        if (bus.in_sof) begin
                            b0_q    <= bus.in_data;
                            state_q <= B1;
                        end
                    end
                    B0: begin
                        b0_q    <= bus.in_data;
                        state_q <= B1;
                    end
                    B1: begin
                        if (bus.in_sof) begin
                            b0_q    <= bus.in_data;
                            state_q <= B1;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {b0_q, bus.in_data[7:4]};
                            wr_h_q    <= h_d;
                            wr_v_q    <= v_d;
                            b1_lo_q   <= bus.in_data[3:0];
                            state_q   <= B2;
                        end
                    end
                    B2: begin
                        if (bus.in_sof) begin
                            b0_q    <= bus.in_data;
                            state_q <= B1;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {b1_lo_q, bus.in_data};
                            wr_h_q    <= h_d;
                            wr_v_q    <= v_d;
                            // Once the frame's last pixel is loaded, only a new
                            // sof may start consuming bytes again.
                            state_q   <= load_last ? WAIT_SOF : B0;
                        end
                    end
                    default: state_q <= WAIT_SOF;
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_h       = wr_h_q;
    assign bus.wr_v       = wr_v_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
endmodule
